// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson (twisted-ring) counter: width-generic
// next-state and legality functions plus reset/preset constants.
package johnson_pkg;

  localparam int MAX_WIDTH  = 64;
  localparam int DEF_WIDTH  = 4;
  localparam int CNT_PERIOD = 2 * DEF_WIDTH;

  typedef logic [MAX_WIDTH-1:0] jc_word_t;

  localparam jc_word_t RESET_VAL  = '0;
  localparam jc_word_t PRESET_VAL = '1;

  // Shift right by one within the low 'width' bits; inverted LSB enters bit width-1.
  function automatic jc_word_t johnson_next(input jc_word_t q, input int unsigned width);
    jc_word_t nxt;
    nxt = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i == int'(width) - 1)
        nxt[i] = ~q[0];
      else if (i < int'(width) - 1)
        nxt[i] = q[(i + 1) % MAX_WIDTH];
    end
    return nxt;
  endfunction

  // Legal Johnson codes are exactly the codes with at most one 0/1 boundary
  // between adjacent bits (all-zeros, all-ones, or one contiguous run of ones
  // touching either end).
  function automatic logic johnson_legal(input jc_word_t q, input int unsigned width);
    int edges;
    edges = 0;
    for (int i = 0; i < MAX_WIDTH - 1; i++) begin
      if ((i < int'(width) - 1) && (q[i] != q[i + 1]))
        edges++;
    end
    return (edges <= 1);
  endfunction

endpackage

// File: rtl/johnson_state_check.sv
// Combinational legality checker for a Johnson counter state; used only when
// JOHNSON_SELF_CORRECT_EN is defined.
module johnson_state_check
  import johnson_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] q,
  output logic             legal
);

  assign legal = johnson_legal(jc_word_t'(q), WIDTH);

endmodule

// File: rtl/johnson_counter.sv
// Parameterised Johnson counter with asynchronous active-low reset and
// asynchronous active-high preset. Define JOHNSON_SELF_CORRECT_EN for illegal-state recovery.
module johnson_counter
  import johnson_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             preset,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] next_q;
  logic             legal;

  assign shifted = WIDTH'(johnson_next(jc_word_t'(q), WIDTH));

`ifdef JOHNSON_SELF_CORRECT_EN
  johnson_state_check #(
    .WIDTH (WIDTH)
  ) u_state_check (
    .q     (q),
    .legal (legal)
  );
`else
  // Without recovery every state is treated as legal; the mux folds away.
  assign legal = 1'b1;
`endif

  assign next_q = legal ? shifted : RESET_VAL[WIDTH-1:0];

  // NOTE: reset is tested before preset so it wins when both are active;
  // sequential state is always assigned with <= to avoid read/write races.
  always_ff @(posedge clk or negedge reset or posedge preset) begin
    if (!reset)
      q <= RESET_VAL[WIDTH-1:0];
    else if (preset)
      q <= PRESET_VAL[WIDTH-1:0];
    else
      q <= next_q;
  end

endmodule

// File: tb/tb_johnson_counter.sv
// Self-checking bench for johnson_counter: directed reset/cycle/preset/priority
// scenarios followed by randomized async events against a sequence-table model.
module tb_johnson_counter;
  import johnson_pkg::*;

  localparam int W = DEF_WIDTH;
  localparam int P = CNT_PERIOD;

  logic         clk;
  logic         reset;
  logic         preset;
  logic [W-1:0] q;

  logic [W-1:0] seq [P];
  logic [W-1:0] exp_q;
  int           n_checks;
  int           n_fail;

  johnson_counter #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .preset (preset),
    .q      (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] req);
    n_checks++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: q=%b expected %b", tag, obs, req);
    end
  endtask

  // Reference: legal codes advance one step along the thermometer sequence
  // table; anything off the table is handled by the recovery policy.
  function automatic logic [W-1:0] model_next(input logic [W-1:0] c);
    for (int k = 0; k < P; k++)
      if (seq[k] === c) return seq[(k + 1) % P];
`ifdef JOHNSON_SELF_CORRECT_EN
    return '0;
`else
    return W'((int'(c) >> 1) | (((~int'(c)) & 1) << (W - 1)));
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (!reset)      exp_q = '0;
    else if (preset) exp_q = '1;
    else             exp_q = model_next(exp_q);
  endtask

  task automatic run_to(input logic [W-1:0] target, input string tag);
    int guard;
    guard = 0;
    while (exp_q !== target && guard < 2 * P) begin
      tick();
      check(tag, q, exp_q);
      guard++;
    end
    check({tag, "_reached"}, q, target);
  endtask

  initial begin
    logic [W-1:0] code;
    int           op;

    n_checks = 0;
    n_fail   = 0;
    // k ones entering from the top, then the ones draining out of the top.
    for (int k = 0; k < P; k++)
      seq[k] = (k <= W) ? W'(((1 << k) - 1) << (W - k)) : W'((1 << (2 * W - k)) - 1);

    reset  = 1'b0;
    preset = 1'b0;
    exp_q  = '0;

    // Reset held 100 ns with clock running.
    repeat (10) begin
      @(negedge clk);
      check("reset_hold", q, '0);
    end
    reset = 1'b1;
    tick();
    check("first_count", q, exp_q);

    // Two full laps from 0000.
    run_to('0, "to_zero");
    for (int i = 0; i < 2 * P; i++) begin
      tick();
      check("full_cycle", q, exp_q);
    end

    // Asynchronous preset pulse between edges while q = 1100.
    run_to(seq[2], "to_1100");
    #2 preset = 1'b1;
    #1 exp_q = '1;
    check("async_preset", q, exp_q);
    #4 preset = 1'b0;
    #1 check("preset_release_hold", q, exp_q);
    tick();
    check("after_preset", q, exp_q);

    // Reset and preset together: reset wins; release reset with preset held.
    #2 reset = 1'b0;
    preset = 1'b1;
    #1 exp_q = '0;
    check("priority_both", q, exp_q);
    #1 reset = 1'b1;
    tick();
    check("priority_preset_only", q, exp_q);
    #2 preset = 1'b0;
    tick();
    check("priority_resume", q, exp_q);

    // Mid-count asynchronous reset at q = 0011.
    run_to(seq[6], "to_0011");
    #2 reset = 1'b0;
    #1 exp_q = '0;
    check("midcount_reset", q, exp_q);
    #1 reset = 1'b1;
    tick();
    check("midcount_restart", q, exp_q);

    // Illegal state 0101 forced in, then observe recovery or parasitic cycle.
    code = 4'b0101;
    #2 force dut.q = code;
    #1 release dut.q;
    #1 exp_q = code;
    check("forced_illegal", q, exp_q);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("illegal_follow", q, exp_q);
    end

    // Randomized mix of clock edges, async pulses and forced codes.
    for (int n = 0; n < 300; n++) begin
      op = int'($urandom_range(0, 9));
      case (op)
        0: begin
          #1 reset = 1'b0;
          #1 exp_q = '0;
          check("rand_reset", q, exp_q);
          #1 reset = 1'b1;
        end
        1: begin
          #1 preset = 1'b1;
          #1 exp_q = '1;
          check("rand_preset", q, exp_q);
          #1 preset = 1'b0;
        end
        2: begin
          code = W'($urandom_range(0, (1 << W) - 1));
          #1 force dut.q = code;
          #1 release dut.q;
          #1 exp_q = code;
          check("rand_force", q, exp_q);
        end
        default: ;
      endcase
      tick();
      check("rand_tick", q, exp_q);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
